// File: rtl/load_store_unit.sv
// Single-entry load/store unit: accepts one instruction from the LS issue queue, performs the
// memory access and, for loads, broadcasts the result on the CDB. Tracks errors and completion counts.
module load_store_unit #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             IssueQue_Ready,
  input  logic             IssueQue_Opcode,
  input  logic [31:0]      IssueQue_Address,
  input  logic [31:0]      IssueQue_Data,
  input  logic [4:0]       IssueQue_Rd_Tag,
  output logic             Issueblk_Issue,
  input  logic             RB_Flush_Valid,
  output logic             Mem_Req,
  output logic             Mem_We,
  output logic [31:0]      Mem_Addr,
  output logic [31:0]      Mem_Wdata,
  input  logic [31:0]      Mem_Rdata,
  input  logic             Mem_Ack,
  output logic             LSU_Cdb_Req,
  output logic [4:0]       LSU_Cdb_Tag,
  output logic [31:0]      LSU_Cdb_Data,
  input  logic             CDB_Grant,
  output logic             LSU_Store_Done,
  output logic             LSU_Error,
  output logic [CNT_W-1:0] LSU_Load_Cnt,
  output logic [CNT_W-1:0] LSU_Store_Cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    CDB  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               is_load, is_load_nxt;
  logic               kill, kill_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic               req_nxt, we_nxt, cdb_req_nxt, done_nxt, err_nxt;
  logic [31:0]        addr_nxt, wdata_nxt, cdb_data_nxt;
  logic [4:0]         tag_nxt;
  logic [CNT_W-1:0]   load_cnt_nxt, store_cnt_nxt;
  logic               issue;
  logic               aligned;

  // Held off during reset so nothing is handed over while the unit is being cleared.
  assign issue          = Rst_n & IssueQue_Ready & (state == IDLE) & ~RB_Flush_Valid;
  assign Issueblk_Issue = issue;
  assign aligned        = (IssueQue_Address[1:0] == 2'b00);

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= IDLE;
      is_load        <= 1'b0;
      kill           <= 1'b0;
      wait_cnt       <= '0;
      Mem_Req        <= 1'b0;
      Mem_We         <= 1'b0;
      Mem_Addr       <= '0;
      Mem_Wdata      <= '0;
      LSU_Cdb_Req    <= 1'b0;
      LSU_Cdb_Tag    <= '0;
      LSU_Cdb_Data   <= '0;
      LSU_Store_Done <= 1'b0;
      LSU_Error      <= 1'b0;
      LSU_Load_Cnt   <= '0;
      LSU_Store_Cnt  <= '0;
    end else begin
      state          <= state_nxt;
      is_load        <= is_load_nxt;
      kill           <= kill_nxt;
      wait_cnt       <= wait_nxt;
      Mem_Req        <= req_nxt;
      Mem_We         <= we_nxt;
      Mem_Addr       <= addr_nxt;
      Mem_Wdata      <= wdata_nxt;
      LSU_Cdb_Req    <= cdb_req_nxt;
      LSU_Cdb_Tag    <= tag_nxt;
      LSU_Cdb_Data   <= cdb_data_nxt;
      LSU_Store_Done <= done_nxt;
      LSU_Error      <= err_nxt;
      LSU_Load_Cnt   <= load_cnt_nxt;
      LSU_Store_Cnt  <= store_cnt_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    is_load_nxt   = is_load;
    kill_nxt      = kill;
    wait_nxt      = wait_cnt;
    req_nxt       = 1'b0;
    we_nxt        = Mem_We;
    addr_nxt      = Mem_Addr;
    wdata_nxt     = Mem_Wdata;
    cdb_req_nxt   = 1'b0;
    tag_nxt       = LSU_Cdb_Tag;
    cdb_data_nxt  = LSU_Cdb_Data;
    done_nxt      = 1'b0;
    err_nxt       = LSU_Error;
    load_cnt_nxt  = LSU_Load_Cnt;
    store_cnt_nxt = LSU_Store_Cnt;

    unique case (state)
      IDLE: begin
        if (issue) begin
          if (aligned) begin
            state_nxt   = MEM;
            is_load_nxt = IssueQue_Opcode;
            kill_nxt    = 1'b0;
            wait_nxt    = '0;
            req_nxt     = 1'b1;
            we_nxt      = ~IssueQue_Opcode;
            addr_nxt    = {IssueQue_Address[31:2], 2'b00};
            wdata_nxt   = IssueQue_Data;
            tag_nxt     = IssueQue_Rd_Tag;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      MEM: begin
        if (Mem_Ack) begin
          state_nxt = IDLE;
          if (is_load) begin
            // A flush on the ack cycle kills the load just like an earlier one.
            if (!(kill || RB_Flush_Valid)) begin
              state_nxt    = CDB;
              cdb_req_nxt  = 1'b1;
              cdb_data_nxt = Mem_Rdata;
            end
          end else begin
            done_nxt      = 1'b1;
            store_cnt_nxt = LSU_Store_Cnt + CNT_W'(1);
          end
          kill_nxt = 1'b0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          kill_nxt  = 1'b0;
        end else begin
          req_nxt  = 1'b1;
          wait_nxt = wait_cnt + WAIT_W'(1);
          if (is_load && RB_Flush_Valid) kill_nxt = 1'b1;
        end
      end

      CDB: begin
        // Grant beats a coincident flush: the result has already been taken.
        if (CDB_Grant) begin
          state_nxt    = IDLE;
          load_cnt_nxt = LSU_Load_Cnt + CNT_W'(1);
        end else if (RB_Flush_Valid) begin
          state_nxt = IDLE;
        end else begin
          cdb_req_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with hand-computed expectations (MEM_TIMEOUT = 4).
module tb_load_store_unit;

  localparam int unsigned CNT_W = 16;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             IssueQue_Ready;
  logic             IssueQue_Opcode;
  logic [31:0]      IssueQue_Address;
  logic [31:0]      IssueQue_Data;
  logic [4:0]       IssueQue_Rd_Tag;
  logic             Issueblk_Issue;
  logic             RB_Flush_Valid;
  logic             Mem_Req;
  logic             Mem_We;
  logic [31:0]      Mem_Addr;
  logic [31:0]      Mem_Wdata;
  logic [31:0]      Mem_Rdata;
  logic             Mem_Ack;
  logic             LSU_Cdb_Req;
  logic [4:0]       LSU_Cdb_Tag;
  logic [31:0]      LSU_Cdb_Data;
  logic             CDB_Grant;
  logic             LSU_Store_Done;
  logic             LSU_Error;
  logic [CNT_W-1:0] LSU_Load_Cnt;
  logic [CNT_W-1:0] LSU_Store_Cnt;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IssueQue_Ready(IssueQue_Ready), .IssueQue_Opcode(IssueQue_Opcode),
    .IssueQue_Address(IssueQue_Address), .IssueQue_Data(IssueQue_Data),
    .IssueQue_Rd_Tag(IssueQue_Rd_Tag), .Issueblk_Issue(Issueblk_Issue),
    .RB_Flush_Valid(RB_Flush_Valid),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
    .LSU_Cdb_Req(LSU_Cdb_Req), .LSU_Cdb_Tag(LSU_Cdb_Tag), .LSU_Cdb_Data(LSU_Cdb_Data),
    .CDB_Grant(CDB_Grant), .LSU_Store_Done(LSU_Store_Done), .LSU_Error(LSU_Error),
    .LSU_Load_Cnt(LSU_Load_Cnt), .LSU_Store_Cnt(LSU_Store_Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic issue_op(input logic op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] tag);
    IssueQue_Ready   = 1'b1;
    IssueQue_Opcode  = op;
    IssueQue_Address = addr;
    IssueQue_Data    = data;
    IssueQue_Rd_Tag  = tag;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    issue_op(1'b1, 32'h100, 32'h0, 5'd7);
    tick;
    total++; if (Issueblk_Issue !== 1'b0) begin bad++; $display("FAIL rst_issue got=%0h exp=0", Issueblk_Issue); end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h exp=0", Mem_Req); end
    total++; if (LSU_Cdb_Req !== 1'b0) begin bad++; $display("FAIL rst_cdb_req got=%0h exp=0", LSU_Cdb_Req); end
    total++; if (LSU_Error !== 1'b0) begin bad++; $display("FAIL rst_error got=%0h exp=0", LSU_Error); end
    total++; if (LSU_Load_Cnt !== 16'd0) begin bad++; $display("FAIL rst_load_cnt got=%0d exp=0", LSU_Load_Cnt); end
    IssueQue_Ready = 1'b0;
    Rst_n = 1'b1;
    tick;
  endtask

  task automatic test_load;
    issue_op(1'b1, 32'h100, 32'h0, 5'd7);
    #1;
    total++; if (Issueblk_Issue !== 1'b1) begin bad++; $display("FAIL load_issue got=%0h exp=1", Issueblk_Issue); end
    tick;
    IssueQue_Ready = 1'b0;
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL load_mem_req got=%0h exp=1", Mem_Req); end
    total++; if (Mem_We !== 1'b0) begin bad++; $display("FAIL load_mem_we got=%0h exp=0", Mem_We); end
    total++; if (Mem_Addr !== 32'h100) begin bad++; $display("FAIL load_mem_addr got=%h exp=00000100", Mem_Addr); end
    Mem_Ack = 1'b1; Mem_Rdata = 32'hDEADBEEF;
    tick;
    Mem_Ack = 1'b0;
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%0h exp=0", Mem_Req); end
    total++; if (LSU_Cdb_Req !== 1'b1) begin bad++; $display("FAIL load_cdb_req got=%0h exp=1", LSU_Cdb_Req); end
    total++; if (LSU_Cdb_Tag !== 5'd7) begin bad++; $display("FAIL load_cdb_tag got=%0d exp=7", LSU_Cdb_Tag); end
    total++; if (LSU_Cdb_Data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_cdb_data got=%h exp=deadbeef", LSU_Cdb_Data); end
    CDB_Grant = 1'b1;
    tick;
    CDB_Grant = 1'b0;
    total++; if (LSU_Cdb_Req !== 1'b0) begin bad++; $display("FAIL load_cdb_drop got=%0h exp=0", LSU_Cdb_Req); end
    total++; if (LSU_Load_Cnt !== 16'd1) begin bad++; $display("FAIL load_cnt got=%0d exp=1", LSU_Load_Cnt); end
  endtask

  task automatic test_store;
    issue_op(1'b0, 32'h204, 32'h12345678, 5'd0);
    tick;
    IssueQue_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL store_req[%0d] got=%0h exp=1", i, Mem_Req); end
      total++; if (Mem_We !== 1'b1) begin bad++; $display("FAIL store_we[%0d] got=%0h exp=1", i, Mem_We); end
      total++; if (Mem_Addr !== 32'h204) begin bad++; $display("FAIL store_addr[%0d] got=%h exp=00000204", i, Mem_Addr); end
      total++; if (Mem_Wdata !== 32'h12345678) begin bad++; $display("FAIL store_wdata[%0d] got=%h exp=12345678", i, Mem_Wdata); end
      if (i == 2) Mem_Ack = 1'b1;
      tick;
    end
    Mem_Ack = 1'b0;
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL store_req_drop got=%0h exp=0", Mem_Req); end
    total++; if (LSU_Store_Done !== 1'b1) begin bad++; $display("FAIL store_done got=%0h exp=1", LSU_Store_Done); end
    total++; if (LSU_Store_Cnt !== 16'd1) begin bad++; $display("FAIL store_cnt got=%0d exp=1", LSU_Store_Cnt); end
    tick;
    total++; if (LSU_Store_Done !== 1'b0) begin bad++; $display("FAIL store_done_pulse got=%0h exp=0", LSU_Store_Done); end
    total++; if (LSU_Cdb_Req !== 1'b0) begin bad++; $display("FAIL store_no_cdb got=%0h exp=0", LSU_Cdb_Req); end
  endtask

  task automatic test_store_flush;
    issue_op(1'b0, 32'h10, 32'h0000BEEF, 5'd0);
    tick;
    IssueQue_Ready = 1'b0;
    RB_Flush_Valid = 1'b1;
    tick;
    RB_Flush_Valid = 1'b0;
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL sflush_req got=%0h exp=1", Mem_Req); end
    Mem_Ack = 1'b1;
    tick;
    Mem_Ack = 1'b0;
    total++; if (LSU_Store_Done !== 1'b1) begin bad++; $display("FAIL sflush_done got=%0h exp=1", LSU_Store_Done); end
    total++; if (LSU_Store_Cnt !== 16'd2) begin bad++; $display("FAIL sflush_cnt got=%0d exp=2", LSU_Store_Cnt); end
    total++; if (LSU_Error !== 1'b0) begin bad++; $display("FAIL sflush_error got=%0h exp=0", LSU_Error); end
  endtask

  task automatic test_flush_load;
    issue_op(1'b1, 32'h300, 32'h0, 5'd3);
    tick;
    IssueQue_Ready = 1'b0;
    RB_Flush_Valid = 1'b1;
    tick;
    RB_Flush_Valid = 1'b0;
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL lflush_wait_req got=%0h exp=1", Mem_Req); end
    Mem_Ack = 1'b1; Mem_Rdata = 32'h11111111;
    tick;
    Mem_Ack = 1'b0;
    total++; if (LSU_Cdb_Req !== 1'b0) begin bad++; $display("FAIL lflush_no_cdb got=%0h exp=0", LSU_Cdb_Req); end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL lflush_req_drop got=%0h exp=0", Mem_Req); end
    issue_op(1'b1, 32'h40, 32'h0, 5'd9);
    #1;
    total++; if (Issueblk_Issue !== 1'b1) begin bad++; $display("FAIL lflush_next_issue got=%0h exp=1", Issueblk_Issue); end
    tick;
    IssueQue_Ready = 1'b0;
    Mem_Ack = 1'b1; Mem_Rdata = 32'hCAFE0001;
    tick;
    Mem_Ack = 1'b0;
    total++; if (LSU_Cdb_Data !== 32'hCAFE0001) begin bad++; $display("FAIL lflush_next_data got=%h exp=cafe0001", LSU_Cdb_Data); end
    total++; if (LSU_Cdb_Tag !== 5'd9) begin bad++; $display("FAIL lflush_next_tag got=%0d exp=9", LSU_Cdb_Tag); end
    CDB_Grant = 1'b1;
    tick;
    CDB_Grant = 1'b0;
    total++; if (LSU_Load_Cnt !== 16'd2) begin bad++; $display("FAIL lflush_load_cnt got=%0d exp=2", LSU_Load_Cnt); end
  endtask

  task automatic test_back_pressure;
    issue_op(1'b1, 32'h80, 32'h0, 5'd21);
    tick;
    IssueQue_Ready = 1'b0;
    Mem_Ack = 1'b1; Mem_Rdata = 32'h55AA33CC;
    tick;
    Mem_Ack = 1'b0; Mem_Rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++; if (LSU_Cdb_Req !== 1'b1) begin bad++; $display("FAIL bp_req[%0d] got=%0h exp=1", i, LSU_Cdb_Req); end
      total++; if (LSU_Cdb_Tag !== 5'd21) begin bad++; $display("FAIL bp_tag[%0d] got=%0d exp=21", i, LSU_Cdb_Tag); end
      total++; if (LSU_Cdb_Data !== 32'h55AA33CC) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=55aa33cc", i, LSU_Cdb_Data); end
      if (i == 4) begin CDB_Grant = 1'b1; RB_Flush_Valid = 1'b1; end
      tick;
    end
    CDB_Grant = 1'b0; RB_Flush_Valid = 1'b0;
    total++; if (LSU_Cdb_Req !== 1'b0) begin bad++; $display("FAIL bp_req_drop got=%0h exp=0", LSU_Cdb_Req); end
    total++; if (LSU_Load_Cnt !== 16'd3) begin bad++; $display("FAIL bp_grant_wins got=%0d exp=3", LSU_Load_Cnt); end
  endtask

  task automatic test_cdb_flush;
    issue_op(1'b1, 32'h44, 32'h0, 5'd1);
    tick;
    IssueQue_Ready = 1'b0;
    Mem_Ack = 1'b1; Mem_Rdata = 32'h00000001;
    tick;
    Mem_Ack = 1'b0;
    total++; if (LSU_Cdb_Req !== 1'b1) begin bad++; $display("FAIL cflush_req got=%0h exp=1", LSU_Cdb_Req); end
    RB_Flush_Valid = 1'b1;
    tick;
    RB_Flush_Valid = 1'b0;
    total++; if (LSU_Cdb_Req !== 1'b0) begin bad++; $display("FAIL cflush_drop got=%0h exp=0", LSU_Cdb_Req); end
    total++; if (LSU_Load_Cnt !== 16'd3) begin bad++; $display("FAIL cflush_cnt got=%0d exp=3", LSU_Load_Cnt); end
  endtask

  task automatic test_timeout;
    issue_op(1'b0, 32'h400, 32'h77777777, 5'd0);
    tick;
    IssueQue_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL tmo_req[%0d] got=%0h exp=1", i, Mem_Req); end
      tick;
    end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL tmo_req_drop got=%0h exp=0", Mem_Req); end
    total++; if (LSU_Error !== 1'b1) begin bad++; $display("FAIL tmo_error got=%0h exp=1", LSU_Error); end
    total++; if (LSU_Store_Done !== 1'b0) begin bad++; $display("FAIL tmo_no_done got=%0h exp=0", LSU_Store_Done); end
    Mem_Ack = 1'b1;
    tick;
    Mem_Ack = 1'b0;
    total++; if (LSU_Store_Done !== 1'b0) begin bad++; $display("FAIL late_ack_done got=%0h exp=0", LSU_Store_Done); end
    total++; if (LSU_Store_Cnt !== 16'd2) begin bad++; $display("FAIL late_ack_cnt got=%0d exp=2", LSU_Store_Cnt); end
  endtask

  task automatic test_misalign;
    issue_op(1'b1, 32'h102, 32'h0, 5'd4);
    #1;
    total++; if (Issueblk_Issue !== 1'b1) begin bad++; $display("FAIL mis_issue got=%0h exp=1", Issueblk_Issue); end
    tick;
    IssueQue_Ready = 1'b0;
    total++; if (LSU_Error !== 1'b1) begin bad++; $display("FAIL mis_error got=%0h exp=1", LSU_Error); end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL mis_req got=%0h exp=0", Mem_Req); end
    tick;
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL mis_req_hold got=%0h exp=0", Mem_Req); end
    total++; if (LSU_Cdb_Req !== 1'b0) begin bad++; $display("FAIL mis_no_cdb got=%0h exp=0", LSU_Cdb_Req); end
  endtask

  task automatic test_reset_mid_mem;
    issue_op(1'b0, 32'h500, 32'hA5A5A5A5, 5'd0);
    tick;
    IssueQue_Ready = 1'b0;
    total++; if (Mem_We !== 1'b1) begin bad++; $display("FAIL rmid_pre_we got=%0h exp=1", Mem_We); end
    Rst_n = 1'b0;
    IssueQue_Ready = 1'b1;
    #1;
    total++; if (Issueblk_Issue !== 1'b0) begin bad++; $display("FAIL rmid_issue got=%0h exp=0", Issueblk_Issue); end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%0h exp=0", Mem_Req); end
    total++; if (Mem_We !== 1'b0) begin bad++; $display("FAIL rmid_we got=%0h exp=0", Mem_We); end
    total++; if (Mem_Addr !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%h exp=0", Mem_Addr); end
    total++; if (Mem_Wdata !== 32'h0) begin bad++; $display("FAIL rmid_wdata got=%h exp=0", Mem_Wdata); end
    total++; if (LSU_Cdb_Tag !== 5'd0) begin bad++; $display("FAIL rmid_tag got=%0d exp=0", LSU_Cdb_Tag); end
    total++; if (LSU_Cdb_Data !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", LSU_Cdb_Data); end
    total++; if (LSU_Error !== 1'b0) begin bad++; $display("FAIL rmid_error got=%0h exp=0", LSU_Error); end
    total++; if (LSU_Load_Cnt !== 16'd0) begin bad++; $display("FAIL rmid_load_cnt got=%0d exp=0", LSU_Load_Cnt); end
    total++; if (LSU_Store_Cnt !== 16'd0) begin bad++; $display("FAIL rmid_store_cnt got=%0d exp=0", LSU_Store_Cnt); end
    IssueQue_Ready = 1'b0;
    tick;
    Rst_n = 1'b1;
    tick;
    issue_op(1'b1, 32'h600, 32'h0, 5'd2);
    tick;
    IssueQue_Ready = 1'b0;
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL rpost_req got=%0h exp=1", Mem_Req); end
    Mem_Ack = 1'b1; Mem_Rdata = 32'h0BADF00D;
    tick;
    Mem_Ack = 1'b0;
    total++; if (LSU_Cdb_Data !== 32'h0BADF00D) begin bad++; $display("FAIL rpost_data got=%h exp=0badf00d", LSU_Cdb_Data); end
    CDB_Grant = 1'b1;
    tick;
    CDB_Grant = 1'b0;
    total++; if (LSU_Load_Cnt !== 16'd1) begin bad++; $display("FAIL rpost_load_cnt got=%0d exp=1", LSU_Load_Cnt); end
  endtask

  initial begin
    Rst_n            = 1'b0;
    IssueQue_Ready   = 1'b0;
    IssueQue_Opcode  = 1'b0;
    IssueQue_Address = 32'h0;
    IssueQue_Data    = 32'h0;
    IssueQue_Rd_Tag  = 5'd0;
    RB_Flush_Valid   = 1'b0;
    Mem_Rdata        = 32'h0;
    Mem_Ack          = 1'b0;
    CDB_Grant        = 1'b0;
    test_reset;
    test_load;
    test_store;
    test_store_flush;
    test_flush_load;
    test_back_pressure;
    test_cdb_flush;
    test_timeout;
    test_misalign;
    test_reset_mid_mem;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the load/store completion counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of cycles to wait for Mem_Ack (range 1..255).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all state is on the rising edge of Clk.
REQ-004 Ports (name, direction, width, meaning):
 Clk  in  1  clock
 Rst_n  in  1  asynchronous, active-low reset
 IssueQue_Ready  in  1  LS queue presents an instruction
 IssueQue_Opcode  in  1  1 = load, 0 = store
 IssueQue_Address  in  32  effective address
 IssueQue_Data  in  32  store data
 IssueQue_Rd_Tag  in  5  load destination tag
 Issueblk_Issue  out  1  instruction accepted this cycle (combinational)
 RB_Flush_Valid  in  1  flush of speculative work
 Mem_Req  out  1  memory request
 Mem_We  out  1  1 = write
 Mem_Addr  out  32  word-aligned address
 Mem_Wdata  out  32  write data
 Mem_Rdata  in  32  read data, valid with Mem_Ack
 Mem_Ack  in  1  request complete
 LSU_Cdb_Req  out  1  load result pending on CDB
 LSU_Cdb_Tag  out  5  result tag
 LSU_Cdb_Data  out  32  result data
 CDB_Grant  in  1  CDB accepts the result this cycle
 LSU_Store_Done  out  1  one-cycle pulse when a store completes
 LSU_Error  out  1  sticky flag: misalignment or timeout
 LSU_Load_Cnt  out  CNT_W  loads broadcast on the CDB
 LSU_Store_Cnt  out  CNT_W  stores completed

Function
REQ-005 The FSM SHALL have states IDLE, MEM and CDB.
REQ-006 Issueblk_Issue SHALL equal IssueQue_Ready & (state==IDLE) & ~RB_Flush_Valid.
REQ-007 On an issue with IssueQue_Address[1:0]==0, the unit SHALL latch opcode, address, data and tag and move to MEM.
REQ-008 On an issue with IssueQue_Address[1:0]!=0, the unit SHALL set LSU_Error, drop the instruction, stay in IDLE, and make no memory access or CDB broadcast.
REQ-009 In MEM, Mem_Req SHALL be 1; Mem_We, Mem_Addr and Mem_Wdata SHALL carry the latched values and stay stable until Mem_Ack.
REQ-010 Mem_Req SHALL be 1 from the cycle after issue through the Mem_Ack cycle inclusive, and 0 in the following cycle.
REQ-011 On Mem_Ack for a load that is not killed, the unit SHALL capture Mem_Rdata into LSU_Cdb_Data and enter CDB.
REQ-012 On Mem_Ack for a store, the unit SHALL pulse LSU_Store_Done in the next cycle, increment LSU_Store_Cnt, and enter IDLE.
REQ-013 In CDB, LSU_Cdb_Req SHALL be 1, with Tag and Data held stable until CDB_Grant.
REQ-014 On CDB_Grant in CDB, the unit SHALL increment LSU_Load_Cnt and enter IDLE; LSU_Cdb_Req SHALL be 0 in the next cycle.
REQ-015 Minimum load latency SHALL be: issue at T, Mem_Ack at T+1, LSU_Cdb_Req at T+2. The next issue is possible in the cycle after the grant.
REQ-016 RB_Flush_Valid in MEM with a load SHALL set a kill flag. The unit waits for Mem_Ack, discards the data, returns to IDLE, and neither raises LSU_Cdb_Req nor increments LSU_Load_Cnt.
REQ-017 RB_Flush_Valid in MEM with a store SHALL NOT affect it, because stores are non-speculative; the store completes normally.
REQ-018 RB_Flush_Valid in CDB SHALL drop the result and force IDLE next cycle, unless CDB_Grant is high in the same cycle. Grant wins: the result counts as delivered.
REQ-019 A wait counter SHALL clear on entry to MEM and increment each MEM cycle without Mem_Ack.
REQ-020 When the wait counter reaches MEM_TIMEOUT, the unit SHALL set LSU_Error, deassert Mem_Req, discard the access, and return to IDLE (no Store_Done, no CDB).
REQ-021 Mem_Ack outside MEM SHALL be ignored.
REQ-022 Counters SHALL wrap modulo 2^CNT_W.
REQ-023 LSU_Error SHALL be cleared only by reset.

Reset
REQ-024 Asserting Rst_n low SHALL immediately force IDLE and clear the kill flag, wait counter, both counters and LSU_Error. Mem_Req, Mem_We, LSU_Cdb_Req and LSU_Store_Done SHALL be 0; Mem_Addr, Mem_Wdata, LSU_Cdb_Tag and LSU_Cdb_Data SHALL be 0.
REQ-025 Reset during MEM SHALL abandon the access without waiting for Mem_Ack.
REQ-026 Issueblk_Issue SHALL be 0 while Rst_n is low.

Verification
REQ-027 Load: Address 0x100, Tag 7, Mem_Ack 1 cycle later with Rdata 0xDEADBEEF, grant immediate -> Cdb_Req one cycle, Tag 7, Data 0xDEADBEEF, Load_Cnt = 1.
REQ-028 Store: Address 0x204, Data 0x12345678, Ack after 3 cycles -> Mem_We = 1, Addr and Wdata stable for 3 cycles, Store_Done pulses once, Store_Cnt = 1.
REQ-029 Flush of a load mid-MEM: flush in MEM, then Ack -> no Cdb_Req, next instruction accepted in the cycle after Ack.
REQ-030 Grant backpressure: CDB_Grant low for 4 cycles -> Cdb_Req, Tag and Data stable for 5 cycles. Flush coincident with grant -> Load_Cnt increments.
REQ-031 Misalign and timeout: Address 0x102 -> Issueblk_Issue = 1, LSU_Error = 1, Mem_Req stays 0. No Ack with MEM_TIMEOUT = 4 -> Mem_Req 0 after 4 cycles, LSU_Error = 1.
REQ-032 Reset mid-MEM: Rst_n low -> all outputs at reset values. The bench releases reset and issues a load, which completes normally.
